seg_scan2: RTL and testbench

Two-digit multiplexed seven-segment scanner that sits directly downstream of the binary-to-decimal splitter. It takes the 4-bit tens and ones BCD digits, double-buffers them so the displayed value changes only on frame boundaries, and time-multiplexes them onto one shared active-low segment bus. Dead-time gaps between digits prevent ghosting. A frame strobe is available to upstream logic.

---
 rtl/seg_scan2.sv | 120 ++++++++++++
 tb/tb_seg_scan2.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/seg_scan2.sv
// Two-digit multiplexed seven-segment scanner with frame-synchronous double buffering.
// Digits are shown ones-then-tens, with all-off gaps between them to avoid ghosting.
module seg_scan2 #(
    parameter int DIGIT_CYC     = 50000,
    parameter int BLANK_CYC     = 500,
    parameter int LEADING_BLANK = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] ten,
    input  logic [3:0] one,
    input  logic       load,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       frame
);

    localparam int MAX_CYC = (DIGIT_CYC > BLANK_CYC) ? DIGIT_CYC : BLANK_CYC;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CW-1:0] DIGIT_LAST = CW'(DIGIT_CYC - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

    typedef enum logic [1:0] {ONES, GAP1, TENS, GAP0} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    pendTen_q, pendTen_d, pendOne_q, pendOne_d;
    logic [3:0]    shadowTen_q, shadowTen_d, shadowOne_q, shadowOne_d;
    logic [6:0]    seg_q, seg_d;
    logic [1:0]    an_q, an_d;
    logic          frame_q, frame_d;
    logic          slotLast;
    logic          frameStart;

    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'd0:    enc = 7'h40;
            4'd1:    enc = 7'h79;
            4'd2:    enc = 7'h24;
            4'd3:    enc = 7'h30;
            4'd4:    enc = 7'h19;
            4'd5:    enc = 7'h12;
            4'd6:    enc = 7'h02;
            4'd7:    enc = 7'h78;
            4'd8:    enc = 7'h00;
            4'd9:    enc = 7'h10;
            default: enc = 7'h06;
        endcase
    endfunction

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_comb begin
        slotLast = (state_q == ONES || state_q == TENS) ? (cnt_q == DIGIT_LAST)
                                                        : (cnt_q == BLANK_LAST);
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        if (slotLast) begin
            cnt_d = '0;
            case (state_q)
                ONES:    state_d = GAP1;
                GAP1:    state_d = TENS;
                TENS:    state_d = GAP0;
                default: state_d = ONES;
            endcase
        end
        frameStart = slotLast && (state_q == GAP0);

        pendTen_d = load ? ten : pendTen_q;
        pendOne_d = load ? one : pendOne_q;
        // Taking the already-updated pending value gives the same-edge load bypass for free.
        shadowTen_d = frameStart ? pendTen_d : shadowTen_q;
        shadowOne_d = frameStart ? pendOne_d : shadowOne_q;

        seg_d = 7'h7F;
        an_d  = 2'b11;
        case (state_d)
            ONES: begin
                an_d  = 2'b10;
                seg_d = enc(shadowOne_d);
            end
            TENS: begin
                if (!(LEADING_BLANK != 0 && shadowTen_d == 4'd0)) begin
                    an_d  = 2'b01;
                    seg_d = enc(shadowTen_d);
                end
            end
            default: ;
        endcase
        frame_d = (state_d == ONES) && (cnt_d == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= GAP0;
            cnt_q       <= BLANK_LAST;
            pendTen_q   <= '0;
            pendOne_q   <= '0;
            shadowTen_q <= '0;
            shadowOne_q <= '0;
            seg_q       <= 7'h7F;
            an_q        <= 2'b11;
            frame_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pendTen_q   <= pendTen_d;
            pendOne_q   <= pendOne_d;
            shadowTen_q <= shadowTen_d;
            shadowOne_q <= shadowOne_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
            frame_q     <= frame_d;
        end
    end

    assign seg   = seg_q;
    assign an    = an_q;
    assign frame = frame_q;

endmodule

// File: tb/tb_seg_scan2.sv
// Bench for seg_scan2: directed vector table, hand sequences, and random traffic
// compared against a frame-position model (two instances: leading blank on and off).
module tb_seg_scan2;

    localparam int D      = 8;
    localparam int B      = 2;
    localparam int PERIOD = 2 * (D + B);

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] ten = 4'd0;
    logic [3:0] one = 4'd0;
    logic       load = 1'b0;
    logic [6:0] segA, segB;
    logic [1:0] anA, anB;
    logic       frameA, frameB;

    int checks = 0;
    int failures = 0;
    int cycle = 0;

    always #5 clk = ~clk;

    seg_scan2 #(.DIGIT_CYC(D), .BLANK_CYC(B), .LEADING_BLANK(1)) dutA (
        .clk(clk), .reset(reset), .ten(ten), .one(one), .load(load),
        .seg(segA), .an(anA), .frame(frameA)
    );

    seg_scan2 #(.DIGIT_CYC(D), .BLANK_CYC(B), .LEADING_BLANK(0)) dutB (
        .clk(clk), .reset(reset), .ten(ten), .one(one), .load(load),
        .seg(segB), .an(anB), .frame(frameB)
    );

    function automatic logic [6:0] encRef(input logic [3:0] d);
        case (d)
            4'd0: encRef = 7'h40;  4'd1: encRef = 7'h79;  4'd2: encRef = 7'h24;
            4'd3: encRef = 7'h30;  4'd4: encRef = 7'h19;  4'd5: encRef = 7'h12;
            4'd6: encRef = 7'h02;  4'd7: encRef = 7'h78;  4'd8: encRef = 7'h00;
            4'd9: encRef = 7'h10;  default: encRef = 7'h06;
        endcase
    endfunction

    // Model: position within the frame (-1 while in reset) plus pending/shown digit pairs.
    int         pos = -1;
    logic [3:0] mPendT = 0, mPendO = 0, mShowT = 0, mShowO = 0;

    always @(posedge clk) begin
        cycle = cycle + 1;
        if (reset) begin
            pos = -1;
            mPendT = 0; mPendO = 0; mShowT = 0; mShowO = 0;
        end else begin
            pos = (pos + 1) % PERIOD;
            if (pos == 0) begin
                mShowT = load ? ten : mPendT;
                mShowO = load ? one : mPendO;
            end
            if (load) begin
                mPendT = ten;
                mPendO = one;
            end
        end
    end

    function automatic logic [9:0] modelOut(input int p, input logic [3:0] t, input logic [3:0] o,
                                            input bit lb);
        if (p < 0)            modelOut = {7'h7F, 2'b11, 1'b0};
        else if (p < D)       modelOut = {encRef(o), 2'b10, p == 0};
        else if (p < D + B)   modelOut = {7'h7F, 2'b11, 1'b0};
        else if (p < 2*D + B) modelOut = (lb && t == 4'd0) ? {7'h7F, 2'b11, 1'b0}
                                                           : {encRef(t), 2'b01, 1'b0};
        else                  modelOut = {7'h7F, 2'b11, 1'b0};
    endfunction

    task automatic checkValue(input string name, input logic [9:0] got, input logic [9:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s cycle=%0d got=%h exp=%h", name, cycle, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic l, input logic [3:0] t, input logic [3:0] o);
        reset = r;
        load  = l;
        ten   = t;
        one   = o;
        @(negedge clk);
    endtask

    task automatic checkOutput();
        logic [9:0] expA, expB;
        expA = modelOut(pos, mShowT, mShowO, 1'b1);
        expB = modelOut(pos, mShowT, mShowO, 1'b0);
        checkValue("modelA_seg", {3'b0, segA}, {3'b0, expA[9:3]});
        checkValue("modelA_an", {8'b0, anA}, {8'b0, expA[2:1]});
        checkValue("modelA_frame", {9'b0, frameA}, {9'b0, expA[0]});
        checkValue("modelB_all", {segB, anB, frameB}, expB);
    endtask

    typedef struct {
        logic       rst;
        logic       ld;
        logic [3:0] t;
        logic [3:0] o;
        logic [6:0] seg;
        logic [1:0] an;
        logic       fr;
        int         n;
    } vec_t;

    vec_t vecs[$];

    initial begin
        // Reset, then an idle frame showing 00 with the tens digit blanked.
        vecs.push_back('{1'b1, 1'b0, 4'd0, 4'd0, 7'h7F, 2'b11, 1'b0, 3});
        vecs.push_back('{1'b0, 1'b0, 4'd0, 4'd0, 7'h40, 2'b10, 1'b1, 1});
        vecs.push_back('{1'b0, 1'b0, 4'd0, 4'd0, 7'h40, 2'b10, 1'b0, 7});
        vecs.push_back('{1'b0, 1'b0, 4'd0, 4'd0, 7'h7F, 2'b11, 1'b0, 2});
        vecs.push_back('{1'b0, 1'b0, 4'd0, 4'd0, 7'h7F, 2'b11, 1'b0, 8});
        vecs.push_back('{1'b0, 1'b0, 4'd0, 4'd0, 7'h7F, 2'b11, 1'b0, 2});
        // Load 7/3 on the frame-start edge: bypass shows it immediately.
        vecs.push_back('{1'b0, 1'b1, 4'd7, 4'd3, 7'h30, 2'b10, 1'b1, 1});
        vecs.push_back('{1'b0, 1'b0, 4'd0, 4'd0, 7'h30, 2'b10, 1'b0, 7});
        vecs.push_back('{1'b0, 1'b0, 4'd0, 4'd0, 7'h7F, 2'b11, 1'b0, 2});
        vecs.push_back('{1'b0, 1'b0, 4'd0, 4'd0, 7'h78, 2'b01, 1'b0, 8});
        vecs.push_back('{1'b0, 1'b0, 4'd0, 4'd0, 7'h7F, 2'b11, 1'b0, 2});
        // Illegal digits 11/15 show E, tens not blanked.
        vecs.push_back('{1'b0, 1'b1, 4'd11, 4'd15, 7'h06, 2'b10, 1'b1, 1});
        vecs.push_back('{1'b0, 1'b0, 4'd0, 4'd0, 7'h06, 2'b10, 1'b0, 7});
        vecs.push_back('{1'b0, 1'b0, 4'd0, 4'd0, 7'h7F, 2'b11, 1'b0, 2});
        vecs.push_back('{1'b0, 1'b0, 4'd0, 4'd0, 7'h06, 2'b01, 1'b0, 8});
        vecs.push_back('{1'b0, 1'b0, 4'd0, 4'd0, 7'h7F, 2'b11, 1'b0, 2});
        // Load 4/2 mid-ONES: current frame unchanged.
        vecs.push_back('{1'b0, 1'b0, 4'd0, 4'd0, 7'h06, 2'b10, 1'b1, 1});
        vecs.push_back('{1'b0, 1'b0, 4'd0, 4'd0, 7'h06, 2'b10, 1'b0, 2});
        vecs.push_back('{1'b0, 1'b1, 4'd4, 4'd2, 7'h06, 2'b10, 1'b0, 1});
        vecs.push_back('{1'b0, 1'b0, 4'd0, 4'd0, 7'h06, 2'b10, 1'b0, 4});
        vecs.push_back('{1'b0, 1'b0, 4'd0, 4'd0, 7'h7F, 2'b11, 1'b0, 2});
        vecs.push_back('{1'b0, 1'b0, 4'd0, 4'd0, 7'h06, 2'b01, 1'b0, 8});
        vecs.push_back('{1'b0, 1'b0, 4'd0, 4'd0, 7'h7F, 2'b11, 1'b0, 2});
        // Shows 4/2; loads 1/1 then 9/8 inside this frame, last one wins.
        vecs.push_back('{1'b0, 1'b0, 4'd0, 4'd0, 7'h24, 2'b10, 1'b1, 1});
        vecs.push_back('{1'b0, 1'b1, 4'd1, 4'd1, 7'h24, 2'b10, 1'b0, 1});
        vecs.push_back('{1'b0, 1'b0, 4'd0, 4'd0, 7'h24, 2'b10, 1'b0, 6});
        vecs.push_back('{1'b0, 1'b0, 4'd0, 4'd0, 7'h7F, 2'b11, 1'b0, 2});
        vecs.push_back('{1'b0, 1'b1, 4'd9, 4'd8, 7'h19, 2'b01, 1'b0, 1});
        vecs.push_back('{1'b0, 1'b0, 4'd0, 4'd0, 7'h19, 2'b01, 1'b0, 7});
        vecs.push_back('{1'b0, 1'b0, 4'd0, 4'd0, 7'h7F, 2'b11, 1'b0, 2});
        vecs.push_back('{1'b0, 1'b0, 4'd0, 4'd0, 7'h00, 2'b10, 1'b1, 1});
        vecs.push_back('{1'b0, 1'b0, 4'd0, 4'd0, 7'h00, 2'b10, 1'b0, 7});
        vecs.push_back('{1'b0, 1'b0, 4'd0, 4'd0, 7'h7F, 2'b11, 1'b0, 2});
        vecs.push_back('{1'b0, 1'b0, 4'd0, 4'd0, 7'h10, 2'b01, 1'b0, 8});
        vecs.push_back('{1'b0, 1'b0, 4'd0, 4'd0, 7'h7F, 2'b11, 1'b0, 2});
        // Load 5/6, then reset mid-TENS with a coincident load that must be ignored.
        vecs.push_back('{1'b0, 1'b1, 4'd5, 4'd6, 7'h02, 2'b10, 1'b1, 1});
        vecs.push_back('{1'b0, 1'b0, 4'd0, 4'd0, 7'h02, 2'b10, 1'b0, 7});
        vecs.push_back('{1'b0, 1'b0, 4'd0, 4'd0, 7'h7F, 2'b11, 1'b0, 2});
        vecs.push_back('{1'b0, 1'b0, 4'd0, 4'd0, 7'h12, 2'b01, 1'b0, 4});
        vecs.push_back('{1'b1, 1'b1, 4'd3, 4'd3, 7'h7F, 2'b11, 1'b0, 1});
        vecs.push_back('{1'b0, 1'b0, 4'd0, 4'd0, 7'h40, 2'b10, 1'b1, 1});
        vecs.push_back('{1'b0, 1'b0, 4'd0, 4'd0, 7'h40, 2'b10, 1'b0, 7});
        vecs.push_back('{1'b0, 1'b0, 4'd0, 4'd0, 7'h7F, 2'b11, 1'b0, 2});
        vecs.push_back('{1'b0, 1'b0, 4'd0, 4'd0, 7'h7F, 2'b11, 1'b0, 8});
        vecs.push_back('{1'b0, 1'b0, 4'd0, 4'd0, 7'h7F, 2'b11, 1'b0, 2});

        foreach (vecs[i]) begin
            for (int k = 0; k < vecs[i].n; k++) begin
                applyStimulus(vecs[i].rst, vecs[i].ld, vecs[i].t, vecs[i].o);
                checkValue("vec_outputs", {segA, anA, frameA},
                           {vecs[i].seg, vecs[i].an, vecs[i].fr});
                checkOutput();
            end
        end

        // Without leading blank, a zero tens digit is shown on its own enable.
        applyStimulus(1'b1, 1'b0, 4'd0, 4'd0);
        checkValue("lb0_reset", {segB, anB, frameB}, {7'h7F, 2'b11, 1'b0});
        for (int k = 0; k < PERIOD; k++) begin
            applyStimulus(1'b0, 1'b0, 4'd0, 4'd0);
            if (k == 0)
                checkValue("lb0_frame", {segB, anB, frameB}, {7'h40, 2'b10, 1'b1});
            if (k == D + B)
                checkValue("lb0_tens", {segB, anB, frameB}, {7'h40, 2'b01, 1'b0});
            checkOutput();
        end

        for (int k = 0; k < 800; k++) begin
            applyStimulus($urandom_range(0, 79) == 0, $urandom_range(0, 5) == 0,
                          4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            checkOutput();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
